// File: rtl/iir_biquad_cascade_pkg.sv
// Shared definitions for the biquad cascade: coefficient slot indices,
// FSM state encoding, history slot layout and the shift/saturate helpers.
// Build option: IIR_CASCADE_ROUND_EN selects round-half-away-from-zero for
// the write-back and output right-shifts; without it the shifts truncate
// toward minus infinity.
package iir_cascade_pkg;

  // Coefficient slot order inside one section.
  localparam logic [2:0] IDX_B0 = 3'd0;
  localparam logic [2:0] IDX_B1 = 3'd1;
  localparam logic [2:0] IDX_B2 = 3'd2;
  localparam logic [2:0] IDX_A1 = 3'd3;
  localparam logic [2:0] IDX_A2 = 3'd4;
  localparam int COEF_IDX_N = 5;

  // History word layout: four samples packed per section.
  localparam int HIST_SLOTS = 4;
  localparam int HIST_X1 = 0;
  localparam int HIST_X2 = 1;
  localparam int HIST_Y1 = 2;
  localparam int HIST_Y2 = 3;

  // Default-width constants.
  localparam int DEF_COEFF_WIDTH = 32;
  localparam logic signed [31:0] UNITY_GAIN = 32'sd65536;
  localparam logic signed [63:0] COEF_ONE = 64'sd1 <<< (DEF_COEFF_WIDTH - 2);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC  = 3'd1,
    ST_WB   = 3'd2,
    ST_GAIN = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  // Wide signed carrier so the helpers serve every width in the block.
  typedef logic signed [127:0] wide_t;

  function automatic wide_t rshift(input wide_t v, input int sh);
`ifdef IIR_CASCADE_ROUND_EN
    wide_t off;
    off = 128'sd1 <<< (sh - 1);
    if (v < 128'sd0) begin
      return -((-v + off) >>> sh);
    end else begin
      return (v + off) >>> sh;
    end
`else
    return v >>> sh;
`endif
  endfunction

  function automatic logic sat_clip(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    return (v > hi) || (v < lo);
  endfunction

  function automatic wide_t saturate(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// Sample stream, coefficient bus and status signals of the biquad cascade.
// master = the surrounding system, slave = the filter.
interface iir_biquad_cascade_if #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int COEFF_WIDTH    = 32,
  parameter int STAGE_W        = 2
);
  logic                             s_valid;
  logic                             s_ready;
  logic signed [IN_DATA_WIDTH-1:0]  x_in;
  logic                             m_valid;
  logic signed [OUT_DATA_WIDTH-1:0] y_out;
  logic                             coef_we;
  logic [STAGE_W+2:0]               coef_addr;
  logic signed [COEFF_WIDTH-1:0]    coef_wdata;
  logic                             coef_commit;
  logic signed [COEFF_WIDTH-1:0]    gain;
  logic                             hist_clr;
  logic                             overflow;
  logic                             ovf_clr;

  modport master (
    output s_valid, x_in, coef_we, coef_addr, coef_wdata, coef_commit,
           gain, hist_clr, ovf_clr,
    input  s_ready, m_valid, y_out, overflow
  );

  modport slave (
    input  s_valid, x_in, coef_we, coef_addr, coef_wdata, coef_commit,
           gain, hist_clr, ovf_clr,
    output s_ready, m_valid, y_out, overflow
  );
endinterface

// File: rtl/iir_biquad_state_ram.sv
// Per-section history store (x1, x2, y1, y2 packed in one word per section).
// Asynchronous read, synchronous write, synchronous clear of every section.
module iir_biquad_state_ram
  import iir_cascade_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_STAGES = 4,
  parameter int STAGE_W    = 2
) (
  input  logic                             clk,
  input  logic                             clr_i,
  input  logic                             we_i,
  input  logic [STAGE_W-1:0]               addr_i,
  input  logic [HIST_SLOTS*DATA_WIDTH-1:0] wdata_i,
  output logic [HIST_SLOTS*DATA_WIDTH-1:0] rdata_o
);
  logic [HIST_SLOTS*DATA_WIDTH-1:0] mem_q [NUM_STAGES];

  // Clear-all has priority over the section write.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of NUM_STAGES direct-form-I biquads sharing one multiplier, with a
// programmable output gain and double-buffered coefficients.
// Build option: IIR_CASCADE_ROUND_EN (rounding instead of truncating shifts).
module iir_biquad_cascade
  import iir_cascade_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 16,
  parameter int COEFF_WIDTH    = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_STAGES     = 4,
  parameter int ACC_WIDTH      = DATA_WIDTH + COEFF_WIDTH + 3,
  parameter int STAGE_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  iir_biquad_cascade_if.slave  bus
);
  localparam int SHIFT_WB   = COEFF_WIDTH - 2;
  localparam int SHIFT_IN   = DATA_WIDTH - IN_DATA_WIDTH;
  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  typedef logic signed [COEFF_WIDTH-1:0] coef_t;
  typedef logic signed [DATA_WIDTH-1:0]  data_t;

  state_t                     state_q, state_d;
  logic [STAGE_W-1:0]         stage_q, stage_d;
  logic [2:0]                 mac_q, mac_d;
  coef_t                      shadow_q [NUM_STAGES][COEF_IDX_N];
  coef_t                      active_q [NUM_STAGES][COEF_IDX_N];
  coef_t                      gain_q;
  data_t                      cur_x_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                       commit_pend_q, hist_pend_q;
  logic                       s_ready_q, m_valid_q, overflow_q;
  logic signed [OUT_DATA_WIDTH-1:0] y_out_q;

  logic [STAGE_W-1:0] wr_stage_s;
  logic [2:0]         wr_idx_s;
  logic               wr_ok_s, accept_s, idle_s, apply_commit_s, apply_hist_s;
  logic [HIST_SLOTS*DATA_WIDTH-1:0] hist_rd_s, hist_wr_s;
  data_t              h_x1_s, h_x2_s, h_y1_s, h_y2_s;
  data_t              mul_a_s, y_sat_s;
  coef_t              mul_b_s;
  logic signed [PROD_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]  prod_acc_s;
  wide_t              y_shift_s, o_shift_s;
  logic               y_clip_s, o_clip_s, clip_s;
  logic signed [OUT_DATA_WIDTH-1:0] o_sat_s;

  assign wr_stage_s = bus.coef_addr[STAGE_W+2:3];
  assign wr_idx_s   = bus.coef_addr[2:0];
  assign wr_ok_s    = bus.coef_we && (wr_idx_s <= IDX_A2) &&
                      (32'(wr_stage_s) < NUM_STAGES);

  assign idle_s         = (state_q == ST_IDLE);
  assign accept_s       = s_ready_q && bus.s_valid;
  assign apply_commit_s = idle_s && commit_pend_q;
  assign apply_hist_s   = idle_s && hist_pend_q;

  iir_biquad_state_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_STAGES (NUM_STAGES),
    .STAGE_W    (STAGE_W)
  ) u_hist (
    .clk     (clk),
    .clr_i   (rst || apply_hist_s),
    .we_i    (state_q == ST_WB),
    .addr_i  (stage_q),
    .wdata_i (hist_wr_s),
    .rdata_o (hist_rd_s)
  );

  assign h_x1_s = hist_rd_s[HIST_X1*DATA_WIDTH +: DATA_WIDTH];
  assign h_x2_s = hist_rd_s[HIST_X2*DATA_WIDTH +: DATA_WIDTH];
  assign h_y1_s = hist_rd_s[HIST_Y1*DATA_WIDTH +: DATA_WIDTH];
  assign h_y2_s = hist_rd_s[HIST_Y2*DATA_WIDTH +: DATA_WIDTH];
  // New history word: slot order y2, y1, x2, x1 from MSB down.
  assign hist_wr_s = {h_y1_s, y_sat_s, h_x1_s, cur_x_q};

  // Shared multiplier operand selection: one MAC term per cycle, gain otherwise.
  always_comb begin
    mul_a_s = cur_x_q;
    mul_b_s = gain_q;
    if (state_q == ST_MAC) begin
      case (mac_q)
        3'd0:    begin mul_a_s = cur_x_q; mul_b_s = active_q[stage_q][IDX_B0]; end
        3'd1:    begin mul_a_s = h_x1_s;  mul_b_s = active_q[stage_q][IDX_B1]; end
        3'd2:    begin mul_a_s = h_x2_s;  mul_b_s = active_q[stage_q][IDX_B2]; end
        3'd3:    begin mul_a_s = h_y1_s;  mul_b_s = active_q[stage_q][IDX_A1]; end
        default: begin mul_a_s = h_y2_s;  mul_b_s = active_q[stage_q][IDX_A2]; end
      endcase
    end else begin
      mul_a_s = cur_x_q;
      mul_b_s = gain_q;
    end
  end

  assign prod_s     = mul_a_s * mul_b_s;
  assign prod_acc_s = ACC_WIDTH'(prod_s);

  // Accumulate feed-forward terms, subtract feedback terms.
  always_comb begin
    acc_d = acc_q;
    if (state_q == ST_MAC) begin
      case (mac_q)
        3'd0:      acc_d = prod_acc_s;
        3'd1, 3'd2: acc_d = acc_q + prod_acc_s;
        default:   acc_d = acc_q - prod_acc_s;
      endcase
    end else begin
      acc_d = acc_q;
    end
  end

  assign y_shift_s = rshift(wide_t'(acc_q), SHIFT_WB);
  assign y_clip_s  = sat_clip(y_shift_s, DATA_WIDTH);
  assign y_sat_s   = DATA_WIDTH'(saturate(y_shift_s, DATA_WIDTH));
  assign o_shift_s = rshift(wide_t'(prod_s), DATA_WIDTH);
  assign o_clip_s  = sat_clip(o_shift_s, OUT_DATA_WIDTH);
  assign o_sat_s   = OUT_DATA_WIDTH'(saturate(o_shift_s, OUT_DATA_WIDTH));
  assign clip_s    = ((state_q == ST_WB) && y_clip_s) ||
                     ((state_q == ST_GAIN) && o_clip_s);

  // FSM state and sequencing counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      mac_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      mac_q   <= mac_d;
    end
  end

  // Next-state: five MAC cycles and one write-back per section, then gain/out.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    mac_d   = mac_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_MAC;
          stage_d = '0;
          mac_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        if (mac_q == 3'd4) begin
          state_d = ST_WB;
          mac_d   = 3'd0;
        end else begin
          mac_d = mac_q + 3'd1;
        end
      end
      ST_WB: begin
        if (stage_q == LAST_STAGE) begin
          state_d = ST_GAIN;
        end else begin
          state_d = ST_MAC;
          stage_d = stage_q + STAGE_W'(1);
        end
      end
      ST_GAIN: state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath, coefficient banks, pending requests and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        for (int k = 0; k < COEF_IDX_N; k++) begin
          shadow_q[s][k] <= '0;
          active_q[s][k] <= '0;
        end
      end
      gain_q        <= '0;
      cur_x_q       <= '0;
      acc_q         <= '0;
      commit_pend_q <= 1'b0;
      hist_pend_q   <= 1'b0;
      s_ready_q     <= 1'b0;
      m_valid_q     <= 1'b0;
      overflow_q    <= 1'b0;
      y_out_q       <= '0;
    end else begin
      if (wr_ok_s) begin
        shadow_q[wr_stage_s][wr_idx_s] <= bus.coef_wdata;
      end
      // The copy samples the shadow bank before this cycle's write lands.
      if (apply_commit_s) begin
        active_q      <= shadow_q;
        commit_pend_q <= bus.coef_commit;
      end else if (bus.coef_commit) begin
        commit_pend_q <= 1'b1;
      end
      if (apply_hist_s) begin
        hist_pend_q <= bus.hist_clr;
      end else if (bus.hist_clr) begin
        hist_pend_q <= 1'b1;
      end
      if (accept_s) begin
        cur_x_q <= data_t'(bus.x_in) <<< SHIFT_IN;
        gain_q  <= bus.gain;
      end else if (state_q == ST_WB) begin
        cur_x_q <= y_sat_s;
      end
      acc_q <= acc_d;
      if (state_q == ST_GAIN) begin
        y_out_q <= o_sat_s;
      end
      m_valid_q <= (state_q == ST_GAIN);
      s_ready_q <= (state_d == ST_IDLE);
      if (clip_s) begin
        overflow_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.y_out    = y_out_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Self-checking bench for iir_biquad_cascade (default truncating build).
module tb_iir_biquad_cascade;
  import iir_cascade_pkg::*;

  localparam int NS = 4;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int CW = 32;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam longint B_ONE  = 64'sd1073741824;   // 2^30
  localparam longint B_HALF = 64'sd536870912;    // 2^29

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   accept_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iir_biquad_cascade_if #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW),
                          .COEFF_WIDTH(CW), .STAGE_W(SW)) bus ();

  iir_biquad_cascade #(.IN_DATA_WIDTH(IW), .OUT_DATA_WIDTH(OW), .COEFF_WIDTH(CW),
                       .DATA_WIDTH(DW), .NUM_STAGES(NS), .STAGE_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  longint m_sh [NS][5];
  longint m_act[NS][5];
  longint m_x1[NS], m_x2[NS], m_y1[NS], m_y2[NS];
  bit     m_cpend, m_hpend, m_ovf;
  longint exp_q[$];

  function automatic longint clip_to(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin m_ovf = 1'b1; return hi; end
    if (v < lo) begin m_ovf = 1'b1; return lo; end
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < 5; k++) begin m_sh[s][k] = 0; m_act[s][k] = 0; end
      m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
    end
    m_cpend = 1'b0; m_hpend = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // One sample through the whole cascade, using the coefficients/history the
  // filter must see for a sample accepted now.
  task automatic model_run(input longint x, output longint y);
    longint v, acc, ys, p;
    if (m_cpend) begin m_act = m_sh; m_cpend = 1'b0; end
    if (m_hpend) begin
      for (int s = 0; s < NS; s++) begin m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0; end
      m_hpend = 1'b0;
    end
    v = x * 65536;
    for (int s = 0; s < NS; s++) begin
      acc = m_act[s][0] * v + m_act[s][1] * m_x1[s] + m_act[s][2] * m_x2[s]
          - m_act[s][3] * m_y1[s] - m_act[s][4] * m_y2[s];
      ys = clip_to(acc >>> 30, DW);
      m_x2[s] = m_x1[s]; m_x1[s] = v; m_y2[s] = m_y1[s]; m_y1[s] = ys;
      v = ys;
    end
    p = v * longint'(bus.gain);
    y = clip_to(p >>> 32, OW);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- bus helpers ----------------
  task automatic write_coef(input int st, input int idx, input longint val);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = {2'(st), 3'(idx)};
    bus.coef_wdata = 32'(val);
    @(negedge clk);
    bus.coef_we = 1'b0;
    if (idx <= 4 && st < NS) m_sh[st][idx] = val;
  endtask

  task automatic pulse_commit();
    bus.coef_commit = 1'b1;
    @(negedge clk);
    bus.coef_commit = 1'b0;
    m_cpend = 1'b1;
  endtask

  task automatic pulse_hist_clr();
    bus.hist_clr = 1'b1;
    @(negedge clk);
    bus.hist_clr = 1'b0;
    m_hpend = 1'b1;
  endtask

  task automatic pulse_ovf_clr();
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic start_sample(input longint x);
    int n;
    longint e;
    n = 0;
    while (!bus.s_ready && n < 200) begin @(negedge clk); n++; end
    chk("s_ready_wait", bus.s_ready, 1);
    bus.x_in    = 16'(x);
    bus.s_valid = 1'b1;
    accept_cyc  = cyc;
    model_run(x, e);
    exp_q.push_back(e);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_output(input string tag, input bit chk_lat);
    int n;
    longint e;
    n = 0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    while (!bus.m_valid && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_seen"}, bus.m_valid, 1);
    if (bus.m_valid) begin
      if (chk_lat) chk({tag, "_lat"}, cyc - accept_cyc, 26);
      chk({tag, "_y"}, bus.y_out, e);
      chk({tag, "_ovf"}, bus.overflow, m_ovf);
      @(negedge clk);
      chk({tag, "_pulse"}, bus.m_valid, 0);
      chk({tag, "_ready"}, bus.s_ready, 1);
    end
  endtask

  task automatic sample(input string tag, input longint x);
    start_sample(x);
    wait_output(tag, 1'b1);
  endtask

  task automatic cfg_passthrough(input longint b0);
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < 5; k++) write_coef(s, k, (k == 0) ? b0 : 64'sd0);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    longint vals[4];
    int idx, outs, prev_acc;
    bus.s_valid = 1'b0; bus.x_in = '0; bus.coef_we = 1'b0; bus.coef_addr = '0;
    bus.coef_wdata = '0; bus.coef_commit = 1'b0; bus.gain = '0;
    bus.hist_clr = 1'b0; bus.ovf_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_y_out", bus.y_out, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // Passthrough
    cfg_passthrough(B_ONE);
    bus.gain = UNITY_GAIN;
    pulse_commit();
    sample("pass_1000", 1000);
    sample("pass_neg", -1234);

    // Impulse response of stage 0 with a1 = -0.5
    write_coef(0, 3, -B_HALF);
    pulse_commit();
    pulse_hist_clr();
    sample("imp0", 1000);
    sample("imp1", 0);
    sample("imp2", 0);
    sample("imp3", 0);
    chk("imp_values_model", m_y1[0] >>> 16, 125);

    // Saturation
    write_coef(0, 3, 0);
    pulse_commit();
    pulse_hist_clr();
    bus.gain = 32'sd131072;
    sample("sat_pos", 20000);
    pulse_ovf_clr();
    chk("ovf_cleared", bus.overflow, 0);
    sample("sat_neg", -20000);
    pulse_ovf_clr();
    chk("ovf_cleared2", bus.overflow, 0);

    // Commit mid-sample takes effect only on the next sample
    bus.gain = UNITY_GAIN;
    start_sample(1000);
    for (int s = 0; s < NS; s++) write_coef(s, 0, B_HALF);
    pulse_commit();
    wait_output("commit_old", 1'b1);
    sample("commit_new", 1600);

    // Backpressure: s_valid held high
    vals[0] = 1600; vals[1] = 3200; vals[2] = -4800; vals[3] = 800;
    idx = 0; outs = 0; prev_acc = -1;
    for (int c = 0; c < 4 * 27 + 40; c++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        chk("bp_y", bus.y_out, (exp_q.size() > 0) ? exp_q.pop_front() : 64'sd99999);
        outs++;
      end
      bus.s_valid = (idx < 4);
      if (idx < 4) bus.x_in = 16'(vals[idx]);
      if (bus.s_ready && idx < 4) begin
        longint e;
        model_run(vals[idx], e);
        exp_q.push_back(e);
        if (prev_acc >= 0) chk("bp_interval", cyc - prev_acc, 27);
        prev_acc = cyc;
        idx++;
      end
    end
    bus.s_valid = 1'b0;
    chk("bp_accepts", idx, 4);
    chk("bp_outs", outs, 4);

    // Reset in the middle of stage 2
    cfg_passthrough(B_ONE);
    write_coef(0, 3, -B_HALF);
    pulse_commit();
    pulse_hist_clr();
    sample("pre_rst", 1000);
    start_sample(0);
    while (cyc < accept_cyc + 15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", bus.s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    outs = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.m_valid) outs++;
    end
    chk("midrst_no_mvalid", outs, 0);
    cfg_passthrough(B_ONE);
    write_coef(0, 3, -B_HALF);
    pulse_commit();
    sample("post_rst", 1000);

    // Random coefficients, gain and samples
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < 5; k++) begin
        write_coef(s, k, longint'($urandom_range(0, 536870912)) - 64'sd268435456);
      end
    end
    write_coef(1, 6, 64'sd123456789);
    pulse_commit();
    pulse_hist_clr();
    bus.gain = 32'(longint'($urandom_range(0, 262144)) - 64'sd131072);
    for (int i = 0; i < 8; i++) begin
      sample("rand", longint'($urandom_range(0, 65535)) - 64'sd32768);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
